multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multi-cycle RV32I core: sequences one instruction over FETCH..WRITEBACK, sharing one ALU and one unified memory.
//  Drives datapath enables/muxes each cycle.
//  Stalls on a memory ready handshake and flags a bus fault on timeout.
// PARAMETERS
//  TIMEOUT  16  max cycles a memory access waits for mem_ready before fault (>=1)
//  CNT_W    32  width of retired-instruction counter (CTRL_PERF_CNT_EN only)
// PORTS
//  clk         in   1   rising-edge clock; single clock domain
//  rst_n       in   1   asynchronous, active-low reset
//  op          in   7   instruction opcode (IR[6:0])
//  funct3      in   3   IR[14:12]
//  funct7b5    in   1   IR[30]
//  zero_flag   in   1   ALU zero result
//  mem_ready   in   1   memory completes current request this cycle
//  mem_req     out  1   memory access request (held until mem_ready)
//  MemWrite    out  1   request is a write (valid with mem_req)
//  AdrSrc      out  1   0: address=PC, 1: address=ALUOut
//  IRWrite     out  1   latch fetched word into IR and OldPC
//  PCWrite     out  1   PC <= Result (PC+4 or target)
//  RegWrite    out  1   register file write
//  ALUSrcA     out  2   00 PC, 01 OldPC, 10 rs1
//  ALUSrcB     out  2   00 rs2, 01 imm, 10 const 4
//  ImmSrc      out  2   00 I, 01 S, 10 B, 11 J
//  ResultSrc   out  2   00 ALUOut, 01 Data, 10 ALU result
//  ALUControl  out  4   0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sll,7 srl,8 sra,9 sltu
//  fault       out  1   sticky bus-timeout / illegal-opcode flag
//  retired     out  CNT_W  retired-instruction count (CTRL_PERF_CNT_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, fault=0, wait cnt=0, retired=0; all outputs combinational from state -> FETCH values.
//  States and transitions:
//   FETCH    mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
//            On mem_ready: IRWrite=1 and PCWrite=1 in that same cycle -> DECODE; else stay.
//   DECODE   ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add (target precompute).
//            Next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL.
//            Any other op -> FAULT.
//   MEMADR   ALUSrcA=10, ALUSrcB=01, ImmSrc=I (load) / S (store), add.
//            -> MEMRD (load) or MEMWR (store).
//   MEMRD    mem_req=1, AdrSrc=1; on mem_ready -> MEMWB.
//   MEMWB    ResultSrc=01, RegWrite=1 -> FETCH.
//   MEMWR    mem_req=1, MemWrite=1, AdrSrc=1; on mem_ready -> FETCH.
//   EXECR    ALUSrcA=10, ALUSrcB=00, ALUControl decoded from funct3/funct7b5 -> ALUWB.
//   EXECI    Same as EXECR but ALUSrcB=01, ImmSrc=I; funct7b5 honoured only for funct3=101 (srai) -> ALUWB.
//   ALUWB    ResultSrc=00, RegWrite=1 -> FETCH.
//   BRANCH   ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
//            PCWrite = zero_flag for funct3=000 (beq), !zero_flag for 001 (bne); other funct3 -> FAULT.
//            -> FETCH.
//   JAL      ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= OldPC+4).
//   FAULT    All enables 0, fault=1; held until reset.
//  Default for every output not listed in a state: 0.
//  Handshake: mem_req stays high with stable AdrSrc/MemWrite until the cycle mem_ready=1; mem_ready while mem_req=0 is ignored.
//  Timeout: wait cnt increments each mem_req cycle without mem_ready and clears on mem_ready or state exit.
//   When cnt reaches TIMEOUT-1 with mem_ready still 0 -> FAULT next cycle.
//   mem_ready on that exact cycle wins: normal progress, no fault.
//  Latency: R/I-type 4 cycles, load 5, store 4, branch 3, jal 4 (zero-wait memory).
//  Reset mid-operation: abandons the instruction; PC/IR are untouched by this block.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined:
//   retired increments by 1 on entry to FETCH from MEMWB, MEMWR, ALUWB or BRANCH; wraps modulo 2^CNT_W; frozen in FAULT.
//  CTRL_PERF_CNT_EN undefined: retired port absent; no counter logic.
// TESTING
//  add x3,x1,x2 with mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; ALUControl=0.
//  lw, mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, AdrSrc=1 stable, then MEMWB with RegWrite=1.
//  beq with zero_flag=1 -> PCWrite=1 in BRANCH; bne with zero_flag=1 -> PCWrite=0.
//  FETCH with mem_ready=0 for 16 cycles (TIMEOUT=16) -> fault=1, state FAULT.
//   Same run with mem_ready=1 on cycle 16 -> no fault.
//  op=7'b1111111 -> FAULT after DECODE; rst_n low mid-EXECR -> all outputs at FETCH values immediately, fault=0.
//  CTRL_PERF_CNT_EN: 3 addi + 1 sw + 1 jal -> retired=5; preload 2^CNT_W-1 then one addi -> retired=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Control FSM for a multi-cycle RV32I core. Sequences a single
//            instruction through FETCH..WRITEBACK, sharing one ALU and one
//            unified memory, and drives the datapath enables/mux selects each
//            cycle. Memory accesses stall on mem_ready_i and raise a sticky
//            fault on timeout; illegal opcodes also fault.
// Ports    : clk, rst_n (async active-low)
//            op_i[6:0], funct3_i[2:0], funct7b5_i  - instruction fields
//            zero_flag_i                           - ALU zero result
//            mem_ready_i                           - memory completes request
//            mem_req_o, MemWrite_o, AdrSrc_o       - memory request controls
//            IRWrite_o, PCWrite_o, RegWrite_o      - datapath write enables
//            ALUSrcA_o, ALUSrcB_o, ImmSrc_o,
//            ResultSrc_o, ALUControl_o             - datapath mux/ALU selects
//            fault_o                               - sticky fault flag
//            retired_o[CNT_W-1:0]                  - retired count (optional)
// Config   : define CTRL_PERF_CNT_EN to add the retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic             zero_flag_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             MemWrite_o,
  output logic             AdrSrc_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ImmSrc_o,
  output logic [1:0]       ResultSrc_o,
  output logic [3:0]       ALUControl_o,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] retired_o,
`endif
  output logic             fault_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_FAULT  = 4'd11
  } state_t;

  localparam int            CW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST   = CW'(TIMEOUT - 1);

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
  localparam logic [6:0] C_OP_BR    = 7'b1100011;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // alt selects sub (funct3=000) or sra (funct3=101); callers decide when
  // funct7b5 is allowed to influence it.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'b000:  r = alt ? 4'd1 : 4'd0;
      3'b001:  r = 4'd6;
      3'b010:  r = 4'd5;
      3'b011:  r = 4'd9;
      3'b100:  r = 4'd4;
      3'b101:  r = alt ? 4'd8 : 4'd7;
      3'b110:  r = 4'd3;
      default: r = 4'd2;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    MemWrite_o   = 1'b0;
    AdrSrc_o     = 1'b0;
    IRWrite_o    = 1'b0;
    PCWrite_o    = 1'b0;
    RegWrite_o   = 1'b0;
    ALUSrcA_o    = 2'b00;
    ALUSrcB_o    = 2'b00;
    ImmSrc_o     = 2'b00;
    ResultSrc_o  = 2'b00;
    ALUControl_o = 4'd0;
    fault_o      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        ImmSrc_o  = 2'b10;
        case (op_i)
          C_OP_LOAD, C_OP_STORE: state_d = S_MEMADR;
          C_OP_RTYPE:            state_d = S_EXECR;
          C_OP_ITYPE:            state_d = S_EXECI;
          C_OP_BR:               state_d = S_BRANCH;
          C_OP_JAL:              state_d = S_JAL;
          default:               state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        // op[5] separates store (0100011) from load (0000011).
        ImmSrc_o  = op_i[5] ? 2'b01 : 2'b00;
        state_d   = op_i[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        AdrSrc_o  = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        RegWrite_o  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o  = 1'b1;
        MemWrite_o = 1'b1;
        AdrSrc_o   = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA_o    = 2'b10;
        ALUControl_o = alu_dec(funct3_i, funct7b5_i);
        state_d      = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA_o    = 2'b10;
        ALUSrcB_o    = 2'b01;
        // IR[30] is immediate data except for srai.
        ALUControl_o = alu_dec(funct3_i, funct7b5_i && (funct3_i == 3'b101));
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o    = 2'b10;
        ALUControl_o = 4'd1;
        case (funct3_i)
          3'b000:  begin PCWrite_o = zero_flag_i;  state_d = S_FETCH; end
          3'b001:  begin PCWrite_o = !zero_flag_i; state_d = S_FETCH; end
          default: state_d = S_FAULT;
        endcase
      end
      S_JAL: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        PCWrite_o = 1'b1;
        state_d   = S_ALUWB;
      end
      S_FAULT: begin
        fault_o = 1'b1;
      end
      default: state_d = S_FAULT;
    endcase

    // A late mem_ready on the last allowed cycle still lets the access finish.
    if (mem_req_o && !mem_ready_i && (cnt_q == C_CNT_LAST)) state_d = S_FAULT;

    // Wait counter only accumulates while the same request keeps stalling.
    if (mem_req_o && !mem_ready_i && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
    else                                                   cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // Count completion only: entry to FETCH from a final state of an instruction.
  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH &&
        (state_q == S_MEMWB || state_q == S_MEMWR ||
         state_q == S_ALUWB || state_q == S_BRANCH))
      retired_d = retired_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired_o = retired_q;
`endif

endmodule

`default_nettype wire
